// File: rtl/multi_bit_adder_if.sv
// Operand/result bundle for multi_bit_adder: the driver owns A/B/C and the adder owns F.
interface multi_bit_adder_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             C;
   logic [WIDTH:0]   F;

   modport master (
      output A,
      output B,
      output C,
      input  F
   );

   modport slave (
      input  A,
      input  B,
      input  C,
      output F
   );
endinterface

// File: rtl/multi_bit_adder.sv
// Registered unsigned adder F = A + B + C built from rippled 4-bit carry-lookahead groups.
module multi_bit_adder #(
   parameter int WIDTH = 16
) (
   input  logic            CLK,
   input  logic            RST,
   multi_bit_adder_if.slave bus
);
   localparam int NGRP = WIDTH / 4;

   if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("multi_bit_adder: WIDTH must be a multiple of 4 and at least 4");
   end

   logic [WIDTH-1:0] sum_w;
   logic             carry_out;

   // Each group resolves its four carries in closed form; only group carries ripple.
   for (genvar k = 0; k < NGRP; k++) begin : g_grp
      logic [3:0] g;
      logic [3:0] p;
      logic [3:0] c;
      logic       cin;
      logic       cout;

      if (k == 0) begin : g_first
         assign cin = bus.C;
      end else begin : g_next
         assign cin = g_grp[k-1].cout;
      end

      assign g = bus.A[4*k +: 4] & bus.B[4*k +: 4];
      assign p = bus.A[4*k +: 4] ^ bus.B[4*k +: 4];

      assign c[0] = cin;
      assign c[1] = g[0] | (p[0] & cin);
      assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & cin);
      assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & cin);

      assign sum_w[4*k +: 4] = p ^ c;
   end

   assign carry_out = g_grp[NGRP-1].cout;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         bus.F <= '0;
      end else begin
         bus.F <= {carry_out, sum_w};
      end
   end
endmodule

// File: tb/tb_multi_bit_adder.sv
// Scoreboard bench for multi_bit_adder: expected sums queued at drive time, checked one edge later.
module tb_multi_bit_adder;
   localparam int WIDTH = 16;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   multi_bit_adder_if #(.WIDTH(WIDTH)) bus ();

   multi_bit_adder #(.WIDTH(WIDTH)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   logic [WIDTH:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   // Drive a vector at the falling edge and queue the reference sum.
   task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
      logic [WIDTH:0] e;
      @(negedge CLK);
      bus.A = a;
      bus.B = b;
      bus.C = c;
      e = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      bus.A = 16'h1234;
      bus.B = 16'h1111;
      bus.C = 1'b1;
      #1;
      n_tests++;
      if (bus.F !== 17'h0) begin
         n_fail++;
         $display("FAIL reset_async got=%h exp=%h", bus.F, 17'h0);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK);
         #1;
         n_tests++;
         if (bus.F !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_hold cycle=%0d got=%h exp=%h", i, bus.F, 17'h0);
         end
      end
      @(negedge CLK);
      RST = 1'b0;
      exp_q.push_back(17'h02346);
      @(posedge CLK);
      #1;
      n_tests++;
      begin
         logic [WIDTH:0] e;
         e = exp_q.pop_front();
         if (bus.F !== e) begin
            n_fail++;
            $display("FAIL reset_release got=%h exp=%h", bus.F, e);
         end
      end
   endtask

   task automatic test_basic();
      logic [WIDTH:0] e;
      drive(16'd5, 16'd7, 1'b0);
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (bus.F !== e || e !== 17'd12) begin
         n_fail++;
         $display("FAIL basic_5_7 got=%0d exp=%0d", bus.F, 17'd12);
      end
      drive(16'd5, 16'd7, 1'b1);
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (bus.F !== e) begin
         n_fail++;
         $display("FAIL basic_carry_in got=%0d exp=%0d", bus.F, e);
      end
      // Inputs moving between edges must not reach F.
      #2;
      bus.A = 16'hAAAA;
      bus.C = 1'b0;
      #1;
      n_tests++;
      if (bus.F !== e) begin
         n_fail++;
         $display("FAIL hold_between_edges got=%0d exp=%0d", bus.F, e);
      end
   endtask

   task automatic test_boundaries();
      logic [WIDTH:0] e;
      drive(16'hFFFF, 16'hFFFF, 1'b1);
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (bus.F !== e || e !== 17'h1FFFF) begin
         n_fail++;
         $display("FAIL max_value got=%h exp=%h", bus.F, 17'h1FFFF);
      end
      drive(16'hFFFF, 16'h0000, 1'b1);
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (bus.F !== e || e !== 17'h10000) begin
         n_fail++;
         $display("FAIL full_ripple got=%h exp=%h", bus.F, 17'h10000);
      end
      drive(16'h0FFF, 16'h0000, 1'b1);
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (bus.F !== e) begin
         n_fail++;
         $display("FAIL ripple_3grp got=%h exp=%h", bus.F, e);
      end
      drive(16'h8000, 16'h8000, 1'b0);
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (bus.F !== e) begin
         n_fail++;
         $display("FAIL msb_carry got=%h exp=%h", bus.F, e);
      end
   endtask

   // New vector every cycle; the check of each edge overlaps the next drive.
   task automatic test_back_to_back();
      logic [WIDTH:0] e;
      int errs = 0;
      for (int i = 0; i <= 64; i++) begin
         for (int j = 0; j <= 64; j++) begin
            for (int c = 0; c < 2; c++) begin
               drive(WIDTH'(i), WIDTH'(j), c[0]);
               @(posedge CLK);
               #1;
               e = exp_q.pop_front();
               n_tests++;
               if (bus.F !== e) begin
                  n_fail++;
                  if (errs < 10) begin
                     $display("FAIL sweep i=%0d j=%0d c=%0d got=%0d exp=%0d", i, j, c, bus.F, e);
                  end
                  errs++;
               end
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [WIDTH:0] e;
      drive(16'hFFFF, 16'hFFFF, 1'b1);
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (bus.F !== e) begin
         n_fail++;
         $display("FAIL pre_reset got=%h exp=%h", bus.F, e);
      end
      #2;
      RST = 1'b1;
      #1;
      n_tests++;
      if (bus.F !== 17'h0) begin
         n_fail++;
         $display("FAIL mid_reset_async got=%h exp=%h", bus.F, 17'h0);
      end
      @(posedge CLK);
      #1;
      n_tests++;
      if (bus.F !== 17'h0) begin
         n_fail++;
         $display("FAIL mid_reset_hold got=%h exp=%h", bus.F, 17'h0);
      end
      exp_q.delete();
      @(negedge CLK);
      RST = 1'b0;
      drive(16'd3, 16'd4, 1'b0);
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (bus.F !== e) begin
         n_fail++;
         $display("FAIL post_reset got=%0d exp=%0d", bus.F, e);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_back_to_back();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
